// File: rtl/fir_sequencer.sv
// FIR control-and-accumulate sequencer: one sample per request, NTAPS serial MACs,
// saturated 17-bit result with a one-cycle strobe and an error flag.
module fir_sequencer #(
    parameter int unsigned NTAPS = 4,
    localparam int unsigned AddrW = $clog2(NTAPS),
    localparam int unsigned AccW  = 17 + AddrW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_ready,
    input  logic [15:0]      sample_data,
    input  logic             coeff_we,
    input  logic [AddrW-1:0] coeff_addr,
    input  logic [15:0]      coeff_data,
    output logic             modwait,
    output logic [16:0]      outreg_data,
    output logic             out_valid,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    localparam logic signed [AccW-1:0] SatHi = AccW'(65535);
    localparam logic signed [AccW-1:0] SatLo = AccW'(-65536);

    state_e state_q, state_d;

    logic [15:0]            x_q [NTAPS];
    logic [15:0]            x_d [NTAPS];
    logic [15:0]            c_q [NTAPS];
    logic [15:0]            c_d [NTAPS];
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [AddrW-1:0]       tap_q, tap_d;
    logic                   drop_q, drop_d;
    logic                   req_q;
    logic                   modwait_q, modwait_d;
    logic                   out_valid_q, out_valid_d;
    logic                   err_q, err_d;
    logic [16:0]            outreg_q, outreg_d;

    logic signed [31:0]     prod;
    logic signed [16:0]     term;
    logic                   new_req;

    // Floor shift by 15 of the full product is simply its top 17 bits.
    assign prod = $signed(x_q[tap_q]) * $signed(c_q[tap_q]);
    assign term = prod[31:15];

    // A held request is one request; only a fresh one arriving while busy is an overrun.
    assign new_req = data_ready & ~req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (data_ready) state_d = StMac;
            StMac:   if (tap_q == AddrW'(NTAPS - 1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_d         = x_q;
        c_d         = c_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        drop_d      = drop_q;
        modwait_d   = modwait_q;
        out_valid_d = 1'b0;
        err_d       = err_q;
        outreg_d    = outreg_q;
        unique case (state_q)
            StIdle: begin
                if (data_ready) begin
                    x_d[0] = sample_data;
                    for (int unsigned i = 1; i < NTAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    acc_d     = '0;
                    tap_d     = '0;
                    drop_d    = 1'b0;
                    modwait_d = 1'b1;
                end else if (coeff_we) begin
                    c_d[coeff_addr] = coeff_data;
                end
            end
            StMac: begin
                acc_d = acc_q + {{(AccW-17){term[16]}}, term};
                tap_d = tap_q + AddrW'(1);
                if (new_req) drop_d = 1'b1;
            end
            StDone: begin
                if (acc_q > SatHi) begin
                    outreg_d = 17'h0FFFF;
                    err_d    = 1'b1;
                end else if (acc_q < SatLo) begin
                    outreg_d = 17'h10000;
                    err_d    = 1'b1;
                end else begin
                    outreg_d = acc_q[16:0];
                    err_d    = drop_q | new_req;
                end
                out_valid_d = 1'b1;
                modwait_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
            acc_q       <= '0;
            tap_q       <= '0;
            drop_q      <= 1'b0;
            req_q       <= 1'b0;
            modwait_q   <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            outreg_q    <= '0;
        end else begin
            x_q         <= x_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            drop_q      <= drop_d;
            req_q       <= data_ready;
            modwait_q   <= modwait_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            outreg_q    <= outreg_d;
        end
    end

    assign modwait     = modwait_q;
    assign out_valid   = out_valid_q;
    assign err         = err_q;
    assign outreg_data = outreg_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer: directed samples push expected results,
// a negedge monitor pops and compares data, error flag and result latency.
module tb_fir_sequencer;

    localparam int unsigned NTAPS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_ready = 1'b0;
    logic [15:0] sample_data = '0;
    logic        coeff_we = 1'b0;
    logic [1:0]  coeff_addr = '0;
    logic [15:0] coeff_data = '0;
    logic        modwait;
    logic [16:0] outreg_data;
    logic        out_valid;
    logic        err;

    fir_sequencer #(.NTAPS(NTAPS)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_ready  (data_ready),
        .sample_data (sample_data),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_data  (coeff_data),
        .modwait     (modwait),
        .outreg_data (outreg_data),
        .out_valid   (out_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [16:0] data;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("outreg_data", 32'(outreg_data), 32'(e.data));
                check("err", 32'(err), 32'(e.err));
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coeff(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        coeff_we   = 1'b1;
        coeff_addr = a;
        coeff_data = d;
        @(negedge clk);
        coeff_we   = 1'b0;
    endtask

    task automatic write_all(input logic [15:0] d);
        for (int i = 0; i < 4; i++) write_coeff(2'(i), d);
    endtask

    // Returns at the negedge just after the accept edge.
    task automatic accept(input logic [15:0] s, input bit push, input logic [16:0] d,
                          input logic e);
        @(negedge clk);
        data_ready  = 1'b1;
        sample_data = s;
        if (push) exp_q.push_back('{data: d, err: e, due: cyc + 1 + NTAPS + 1});
        @(negedge clk);
        data_ready = 1'b0;
        check("modwait_busy", 32'(modwait), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!modwait) begin
                idle = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!idle) check("modwait_timeout", 32'(modwait), 32'd0);
    endtask

    task automatic send(input logic [15:0] s, input logic [16:0] d, input logic e);
        accept(s, 1'b1, d, e);
        wait_idle();
    endtask

    initial begin
        int unsigned a0;

        // Reset state
        rst = 1'b1;
        #2;
        check("rst_modwait", 32'(modwait), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_outreg", 32'(outreg_data), 32'd0);
        do_reset();

        // Impulse-style accumulation with c = 0.5
        write_all(16'h4000);
        send(16'd100, 17'd50, 1'b0);
        send(16'd200, 17'd150, 1'b0);
        send(16'd300, 17'd300, 1'b0);
        send(16'd400, 17'd500, 1'b0);

        // Positive saturation
        do_reset();
        write_all(16'h7FFF);
        send(16'h7FFF, 17'd32766, 1'b0);
        send(16'h7FFF, 17'd65532, 1'b0);
        send(16'h7FFF, 17'h0FFFF, 1'b1);
        send(16'h7FFF, 17'h0FFFF, 1'b1);

        // Negative saturation
        do_reset();
        write_all(16'h7FFF);
        send(16'h8000, 17'h18001, 1'b0);
        send(16'h8000, 17'h10002, 1'b0);
        send(16'h8000, 17'h10000, 1'b1);
        send(16'h8000, 17'h10000, 1'b1);

        // Overrun: request pulsed at E2 is dropped and flags the current result only
        do_reset();
        write_all(16'h4000);
        accept(16'd100, 1'b1, 17'd50, 1'b1);
        @(negedge clk);
        data_ready  = 1'b1;
        sample_data = 16'd9999;
        @(negedge clk);
        data_ready  = 1'b0;
        wait_idle();
        send(16'd200, 17'd150, 1'b0);

        // Coefficient write during MAC ignored; same write in IDLE takes effect
        do_reset();
        write_all(16'h4000);
        accept(16'd100, 1'b1, 17'd50, 1'b0);
        coeff_we   = 1'b1;
        coeff_addr = 2'd0;
        coeff_data = 16'h7FFF;
        @(negedge clk);
        coeff_we = 1'b0;
        wait_idle();
        write_coeff(2'd0, 16'h7FFF);
        send(16'd200, 17'd249, 1'b0);

        // Reset mid-computation
        do_reset();
        write_all(16'h4000);
        send(16'd100, 17'd50, 1'b0);
        send(16'd200, 17'd150, 1'b0);
        accept(16'd300, 1'b0, 17'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_modwait", 32'(modwait), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_outreg", 32'(outreg_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_modwait", 32'(modwait), 32'd0);
        write_all(16'h4000);
        send(16'd1000, 17'd500, 1'b0);

        // Back-to-back with data_ready held high
        do_reset();
        write_all(16'h4000);
        @(negedge clk);
        data_ready  = 1'b1;
        sample_data = 16'd40;
        a0 = cyc + 1;
        exp_q.push_back('{data: 17'd20, err: 1'b0, due: a0 + 5});
        exp_q.push_back('{data: 17'd40, err: 1'b0, due: a0 + 11});
        exp_q.push_back('{data: 17'd60, err: 1'b0, due: a0 + 17});
        repeat (13) @(negedge clk);
        data_ready = 1'b0;
        wait_idle();

        repeat (10) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Control-and-accumulate sequencer for the FIR path: accepts one 16-bit signed sample per request, shifts it into an NTAPS-deep delay line, and runs one multiply-accumulate per cycle against a loadable coefficient bank. It produces the 17-bit signed `outreg_data` word consumed by the `magnitude` block. It handles busy signalling (`modwait`), result strobing and saturation/overrun error reporting.

## Interface
- `NTAPS`, 4: number of taps; power of two, ≥2.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous active-high reset.
- `data_ready` in 1: sample request; `sample_data` is valid while high.
- `sample_data` in 16: signed input sample.
- `coeff_we` in 1: coefficient write strobe.
- `coeff_addr` in $clog2(NTAPS): coefficient index.
- `coeff_data` in 16: signed Q1.15 coefficient.
- `modwait` out 1: high while a computation is in progress.
- `outreg_data` out 17: signed result, feeds `magnitude.in`.
- `out_valid` out 1: one-cycle strobe, new `outreg_data` present.
- `err` out 1: error for the current result, qualified by `out_valid`.

## Operation
- States: IDLE, MAC, DONE.
- IDLE, `data_ready`=1 on an edge (accept edge):
  - delay line shifts: x[0]←`sample_data`, x[i]←x[i-1], x[NTAPS-1] dropped.
  - acc←0, tap←0, drop flag←0, `modwait`←1, state→MAC.
- MAC, each edge:
  - acc += (x[tap]·c[tap]) >>> 15, with a 32-bit signed product and arithmetic (floor) shift, giving a 17-bit term.
  - acc is NTAPS-term wide: 19 bits for NTAPS=4, i.e. 17+$clog2(NTAPS).
  - tap++; after tap=NTAPS-1 is accumulated, state→DONE.
- DONE edge:
  - acc > 65535: `outreg_data`←17'h0FFFF, saturated.
  - acc < -65536: `outreg_data`←17'h10000, saturated.
  - otherwise `outreg_data`←acc[16:0].
  - `err`←saturated | drop flag.
  - `out_valid`←1 for exactly one cycle; `modwait`←0; state→IDLE.
- `data_ready` high in MAC or DONE: sample dropped, delay line unchanged, drop flag←1.
- `data_ready` is level-sampled. A request held high across the DONE→IDLE edge is accepted on the first IDLE edge.
- Coefficient writes:
  - c[`coeff_addr`]←`coeff_data` only when state=IDLE and `data_ready`=0.
  - Writes are ignored otherwise, with no error. `data_ready` has priority.
- `outreg_data` and `err` hold their value until the next DONE.

## Timing
- Accept edge E0; MAC edges E1..E_NTAPS; DONE edge E_(NTAPS+1).
- For NTAPS=4: result and `out_valid` registered at E5, i.e. 5 edges after acceptance.
- `modwait` is high from after E0 until E_(NTAPS+1). Next accept is possible at E_(NTAPS+2), giving a throughput of one sample per NTAPS+2 cycles.
- All outputs are registered; no combinational input→output path.
- Reset values, applied immediately on `rst` assertion including mid-computation:
  - state=IDLE.
  - `modwait`=0, `out_valid`=0, `err`=0, `outreg_data`=0.
  - acc=0, tap=0, delay line all 0, coefficients all 0.
- A partial result is never emitted after reset.

## Test plan
- Impulse: reset, write all c=16'h4000, samples 100, 200, 300, 400 with `data_ready` one cycle each, waiting out `modwait` -> `outreg_data` = 50, 150, 300, 500; `err`=0; each `out_valid` exactly 5 edges after its accept edge.
- Positive saturation: c all 16'h7FFF, four samples 16'h7FFF -> 4th result acc=131064 -> `outreg_data`=17'h0FFFF, `err`=1. A negative case with c=16'h7FFF, x=16'h8000 ×4 -> 17'h10000, `err`=1.
- Overrun: pulse `data_ready` at E2 of a computation -> that sample is not in the delay line; the current result has `err`=1; the next result has `err`=0 if not saturated.
- Coefficient gating: `coeff_we` to addr 0 with 16'h7FFF during MAC -> c[0] unchanged, and the next result matches the old coefficients. The same write in IDLE takes effect.
- Reset mid-run: assert `rst` at E3 -> outputs and state reset immediately, no `out_valid`. After release, a sample of 1000 with c[0]=16'h4000 yields 500, showing the delay line was cleared.
- Back-to-back: `data_ready` held high continuously -> accepts at E0, E6, E12, and so on; no drops and `err`=0.
